// File: rtl/weight_kernel_fetch_pp.sv
`default_nettype none
// ============================================================================
// Module      : weight_kernel_fetch_pp
// Description : BRAM bank pool that assembles per-PE/per-mesh kernels of a
//               runtime tap count. Next fetch overlaps output consumption.
//               Optional sticky conf_err output: define WB_CONF_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_kernel_fetch_pp #(
    parameter int X_PE         = 16,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 10,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256,
    parameter int KMAX         = 9,
    parameter int TAPW         = 4,
    parameter int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DDR_DATA_LEN-1:0]          wr_data,
    input  logic [ADDR_LEN-1:0]              wr_addr,
    input  logic [BUFFER_NUM-1:0]            wr_en,
    input  logic                             rd_conf,
    input  logic [ADDR_LEN-1:0]              rd_addr,
    input  logic [TAPW-1:0]                  rd_taps,
    output logic [X_PE*X_MESH*8*KMAX-1:0]    ker_out,
    output logic                             ker_valid,
    input  logic                             ker_ready,
    output logic                             idle
`ifdef WB_CONF_ERR_EN
    ,
    output logic                             conf_err
`endif
);

    localparam int NBYTES = X_PE * X_MESH;
    localparam int WORD_W = 8 * NBYTES;
    localparam int GROUPS = DDR_DATA_LEN / DATA_LEN;
    localparam int CNTW   = $clog2(KMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_XFER     = 2'd2,
        S_WAIT_OUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] base_q;
    logic [CNTW-1:0]     taps_q;
    logic [CNTW-1:0]     rcnt_q;
    logic                cap_vld_q;
    logic [CNTW-1:0]     cap_slot_q;
    logic [WORD_W-1:0]   stage_q [KMAX];
    logic [WORD_W-1:0]   ker_q   [KMAX];
    logic                ker_valid_q;

    logic [WORD_W-1:0]   rd_word_w;
    logic [ADDR_LEN-1:0] rd_addr_w;
    logic [CNTW-1:0]     taps_clamp_w;
    logic                rd_en_w;
    logic                copy_w;
    logic                accept_w;
    logic                idle_w;
    logic                can_copy_w;

    assign rd_addr_w    = base_q + ADDR_LEN'(rcnt_q);
    assign taps_clamp_w = (rd_taps == '0)            ? CNTW'(1)    :
                          (rd_taps > TAPW'(KMAX))    ? CNTW'(KMAX) :
                                                       CNTW'(rd_taps);
    assign can_copy_w   = !ker_valid_q || ker_ready;

    // Each bank holds one DATA_LEN slice of the full per-tap word; the DDR bus
    // is replicated so bank j takes slice j mod GROUPS.
    generate
        for (genvar j = 0; j < BUFFER_NUM; j++) begin : g_bank
            logic [DATA_LEN-1:0] mem_q [2**ADDR_LEN];
            logic [DATA_LEN-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (wr_en[j]) begin
                    mem_q[wr_addr] <= wr_data[(j % GROUPS)*DATA_LEN +: DATA_LEN];
                end
                if (rd_en_w) begin
                    dout_q <= mem_q[rd_addr_w];
                end
            end

            assign rd_word_w[j*DATA_LEN +: DATA_LEN] = dout_q;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        idle_w   = 1'b0;
        rd_en_w  = 1'b0;
        copy_w   = 1'b0;
        accept_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_w = 1'b1;
            end
            S_FETCH: begin
                rd_en_w = (rcnt_q < taps_q);
                if (cap_vld_q && (cap_slot_q == taps_q - CNTW'(1))) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (can_copy_w) begin
                    copy_w  = 1'b1;
                    idle_w  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT: begin
                if (can_copy_w) begin
                    copy_w  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rd_conf && idle_w) begin
            accept_w = 1'b1;
            state_d  = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            taps_q      <= '0;
            rcnt_q      <= '0;
            cap_vld_q   <= 1'b0;
            cap_slot_q  <= '0;
            ker_valid_q <= 1'b0;
            for (int k = 0; k < KMAX; k++) begin
                stage_q[k] <= '0;
                ker_q[k]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            cap_vld_q  <= rd_en_w;
            cap_slot_q <= rcnt_q;
            if (accept_w) begin
                base_q <= rd_addr;
                taps_q <= taps_clamp_w;
                rcnt_q <= '0;
            end else if (rd_en_w) begin
                rcnt_q <= rcnt_q + CNTW'(1);
            end
            // Bank output registers hold the word read one edge earlier.
            for (int k = 0; k < KMAX; k++) begin
                if (cap_vld_q && (cap_slot_q == CNTW'(k))) begin
                    stage_q[k] <= rd_word_w;
                end
            end
            if (copy_w) begin
                ker_valid_q <= 1'b1;
                for (int k = 0; k < KMAX; k++) begin
                    ker_q[k] <= (CNTW'(k) < taps_q) ? stage_q[k] : '0;
                end
            end else if (ker_valid_q && ker_ready) begin
                ker_valid_q <= 1'b0;
            end
        end
    end

`ifdef WB_CONF_ERR_EN
    logic conf_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conf_err_q <= 1'b0;
        end else if (rd_conf && !idle_w) begin
            conf_err_q <= 1'b1;
        end
    end

    assign conf_err = conf_err_q;
`endif

    generate
        for (genvar b = 0; b < NBYTES; b++) begin : g_byte
            for (genvar k = 0; k < KMAX; k++) begin : g_tap
                assign ker_out[(b*KMAX + k)*8 +: 8] = ker_q[k][b*8 +: 8];
            end
        end
    endgenerate

    assign ker_valid = ker_valid_q;
    assign idle      = idle_w;

endmodule
`default_nettype wire
